// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register-select widths and the register-file FSM state.
// Parametrisation-independent so every datapath block can import it.
package cpu_types_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_SEL_W = $clog2(NUM_REGS);

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_SEL_W-1:0] reg_sel_t;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W_DEFAULT = $bits(word_t);
    localparam int RF_DEPTH_DEFAULT  = NUM_REGS;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, reserve beats write-clear,
// register 0 never busy when ZERO_REG=1. clr_i wipes every bit at the edge.
module regfile_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int DEPTH    = RF_DEPTH_DEFAULT,
    parameter int AW       = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 CLK,
    input  logic                 clr_i,
    input  logic [NWRITE-1:0]    wen_i,
    input  logic [NWRITE*AW-1:0] wsel_i,
    input  logic                 rsv_en_i,
    input  logic [AW-1:0]        rsv_sel_i,
    input  logic [NREAD*AW-1:0]  rsel_i,
    output logic [NREAD-1:0]     rbusy_o
);

    logic [DEPTH-1:0] busy_q;

    always_ff @(posedge CLK) begin
        if (clr_i) begin
            busy_q <= '0;
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                if (wen_i[w]) begin
                    busy_q[wsel_i[w*AW +: AW]] <= 1'b0;
                end
            end
            // Applied last so a new producer's reservation survives a same-cycle write.
            if (rsv_en_i) begin
                busy_q[rsv_sel_i] <= 1'b1;
            end
            if (ZERO_REG != 0) begin
                busy_q[0] <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_lookup
            logic [AW-1:0] ra;
            assign ra = rsel_i[gi*AW +: AW];
            assign rbusy_o[gi] = busy_q[ra] & ~((ZERO_REG != 0) && (ra == '0));
        end
    endgenerate

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with sequenced post-reset clear and pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module register_file_mp
    import cpu_types_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEFAULT,
    parameter int DEPTH    = RF_DEPTH_DEFAULT,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*AW-1:0]     wsel,
    input  logic [NWRITE*DATA_W-1:0] wdat,
    input  logic [NREAD*AW-1:0]      rsel,
    output logic [NREAD*DATA_W-1:0]  rdat,
    output logic [NREAD-1:0]         rbusy,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_sel,
    output logic                     ready
);

    localparam logic [AW:0] CNT_DONE = DEPTH[AW:0];
    localparam logic [AW:0] CNT_ONE  = 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    rf_state_t         state_q, state_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              run;
    logic              sweep_we;
    logic [NWRITE-1:0] wen_eff;
    logic              rsv_eff;
    logic [NREAD-1:0]  sb_rbusy;
    logic [AW-1:0]     wa [NWRITE];
    logic [DATA_W-1:0] wd [NWRITE];

    assign run      = (state_q == RF_RUN);
    assign ready    = run;
    assign sweep_we = (state_q == RF_CLEAR) && !cnt_q[AW];
    assign rsv_eff  = rsv_en & run;

    genvar gi;
    generate
        for (gi = 0; gi < NWRITE; gi++) begin : g_wr
            assign wa[gi] = wsel[gi*AW +: AW];
            assign wd[gi] = wdat[gi*DATA_W +: DATA_W];
            assign wen_eff[gi] = wen[gi] & run & ~((ZERO_REG != 0) && (wa[gi] == '0));
        end
    endgenerate

    // The counter runs one past DEPTH-1 so the last clear and the move to RUN are separate edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_CLEAR) begin
            if (cnt_q == CNT_DONE) begin
                state_d = RF_RUN;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // No flop reset on the array; the sweep zeroes it one word per cycle.
    always_ff @(posedge CLK) begin
        if (sweep_we) begin
            mem_q[cnt_q[AW-1:0]] <= '0;
        end else begin
            for (int i = 0; i < NWRITE; i++) begin
                if (wen_eff[i]) begin
                    mem_q[wa[i]] <= wd[i];
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NREAD    (NREAD),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .CLK       (CLK),
        .clr_i     (RST | ~run),
        .wen_i     (wen_eff),
        .wsel_i    (wsel),
        .rsv_en_i  (rsv_eff),
        .rsv_sel_i (rsv_sel),
        .rsel_i    (rsel),
        .rbusy_o   (sb_rbusy)
    );

    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0]     ra;
            logic [DATA_W-1:0] rd;
            logic              hit;

            assign ra = rsel[gi*AW +: AW];

            always_comb begin
                rd  = mem_q[ra];
                hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NWRITE; w++) begin
                    if (wen_eff[w] && (wa[w] == ra)) begin
                        rd  = wd[w];
                        hit = 1'b1;
                    end
                end
`endif
                if (!run || ((ZERO_REG != 0) && (ra == '0))) begin
                    rd = '0;
                end
            end

            assign rdat[gi*DATA_W +: DATA_W] = rd;
            // A forwarded write resolves the hazard unless a new reservation lands on the same register.
            assign rbusy[gi] = run & sb_rbusy[gi] & ~(hit & ~(rsv_en & (rsv_sel == ra)));
        end
    endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised + directed bench for register_file_mp (NREAD=2, NWRITE=2, DEPTH=32, ZERO_REG=1).
// Outputs are compared every cycle against an array/flag model of the register file.
module tb_register_file_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int AW    = 5;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [NW-1:0]    wen = '0;
    logic [NW*AW-1:0] wsel = '0;
    logic [NW*DW-1:0] wdat = '0;
    logic [NR*AW-1:0] rsel = '0;
    logic [NR*DW-1:0] rdat;
    logic [NR-1:0]    rbusy;
    logic             rsv_en = 1'b0;
    logic [AW-1:0]    rsv_sel = '0;
    logic             ready;

    int errors = 0;
    int checks = 0;

    register_file_mp #(
        .DATA_W(DW), .DEPTH(DEPTH), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1)
    ) dut (
        .CLK(CLK), .RST(RST), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel), .ready(ready)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_ready = 1'b0;
    bit            m_valid = 1'b0;
    int            m_edges = 0;   // low-RST edges seen since the last reset

    function automatic logic [AW-1:0] raddr(int p);
        return rsel[p*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] waddr(int w);
        return wsel[w*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] exp_rdat(int p);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = raddr(p);
        if (!m_ready || a == 0) return '0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NW; w++)
            if (wen[w] && waddr(w) == a) v = wdat[w*DW +: DW];
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(int p);
        logic [AW-1:0] a;
        logic          b;
        a = raddr(p);
        if (!m_ready || a == 0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NW; w++)
            if (wen[w] && waddr(w) == a && !(rsv_en && rsv_sel == a)) b = 1'b0;
`endif
        return b;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_valid <= 1'b1;
            m_ready <= 1'b0;
            m_edges <= 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  <= '0;
                m_busy[i] <= 1'b0;
            end
        end else if (!m_ready) begin
            // Sweep clears DEPTH words, then one more edge enters RUN.
            m_edges <= m_edges + 1;
            if (m_edges == DEPTH) m_ready <= 1'b1;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (wen[w] && waddr(w) != 0) begin
                    m_mem[waddr(w)]  <= wdat[w*DW +: DW];
                    m_busy[waddr(w)] <= 1'b0;
                end
            end
            if (rsv_en && rsv_sel != 0) m_busy[rsv_sel] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Single compare process: every cycle once the model has seen a reset.
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("ready", 64'(ready), 64'(m_ready));
            for (int p = 0; p < NR; p++) begin
                chk("rdat", 64'(rdat[p*DW +: DW]), 64'(exp_rdat(p)));
                chk("rbusy", 64'(rbusy[p]), 64'(exp_rbusy(p)));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        wen = '0;
        rsv_en = 1'b0;
    endtask

    task automatic set_w(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen[w] = 1'b1;
        wsel[w*AW +: AW] = a;
        wdat[w*DW +: DW] = d;
    endtask

    task automatic set_r(input int p, input logic [AW-1:0] a);
        rsel[p*AW +: AW] = a;
    endtask

    // Counts edges after release until ready; ready must appear after exactly DEPTH+1 low edges.
    task automatic wait_ready(input string name, input bit poke_writes);
        int edges;
        edges = 0;
        while (!ready && edges < 200) begin
            step();
            edges++;
            if (poke_writes && edges == 5) begin
                set_w(0, 5'd9, 32'hDEAD_BEEF);
                set_w(1, 5'd31, 32'hCAFE_F00D);
                rsv_en = 1'b1;
                rsv_sel = 5'd9;
            end
            if (poke_writes && edges == 6) idle_inputs();
        end
        chk(name, 64'(edges), 64'(DEPTH + 1));
    endtask

    initial begin
        logic [DW-1:0] exp_same;

        RST = 1'b1;
        repeat (3) step();
        RST = 1'b0;
        wait_ready("ready_latency", 1'b1);

        // All registers read zero after the sweep, including the ones poked during it.
        for (int r = 0; r < DEPTH; r += 2) begin
            set_r(0, 5'(r));
            set_r(1, 5'(r + 1));
            @(negedge CLK);
            chk("clear_rd0", 64'(rdat[0 +: DW]), 64'h0);
            chk("clear_rd1", 64'(rdat[DW +: DW]), 64'h0);
            chk("clear_busy", 64'(rbusy), 64'h0);
            step();
        end

        // Write priority and hardwired zero.
        set_w(0, 5'd5, 32'hAAAA_0000);
        set_w(1, 5'd5, 32'h0000_BBBB);
        step();
        idle_inputs();
        set_w(0, 5'd0, 32'hFFFF_FFFF);
        step();
        idle_inputs();
        set_r(0, 5'd5);
        set_r(1, 5'd0);
        @(negedge CLK);
        chk("wr_priority", 64'(rdat[0 +: DW]), 64'h0000_BBBB);
        chk("zero_reg", 64'(rdat[DW +: DW]), 64'h0);

        // Scoreboard on r7.
        step();
        set_r(0, 5'd7);
        rsv_en = 1'b1; rsv_sel = 5'd7;
        step();
        idle_inputs();
        @(negedge CLK);
        chk("sb_reserve", 64'(rbusy[0]), 64'h1);
        step();
        set_w(0, 5'd7, 32'h7777_0000);
        step();
        idle_inputs();
        @(negedge CLK);
        chk("sb_write_clr", 64'(rbusy[0]), 64'h0);
        step();
        set_w(1, 5'd7, 32'h7777_1111);
        rsv_en = 1'b1; rsv_sel = 5'd7;
        step();
        idle_inputs();
        @(negedge CLK);
        chk("sb_rsv_wins", 64'(rbusy[0]), 64'h1);

        // Bypass / no-bypass on r3.
        step();
        set_w(0, 5'd3, 32'h1111_0000);
        step();
        set_w(0, 5'd3, 32'h1234_5678);
        set_r(1, 5'd3);
        @(negedge CLK);
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h1234_5678;
`else
        exp_same = 32'h1111_0000;
`endif
        chk("bypass_same", 64'(rdat[DW +: DW]), 64'(exp_same));
        step();
        idle_inputs();
        @(negedge CLK);
        chk("bypass_after", 64'(rdat[DW +: DW]), 64'h1234_5678);

        // Reset in RUN: busy wiped and reads zero.
        step();
        rsv_en = 1'b1; rsv_sel = 5'd9;
        set_w(0, 5'd4, 32'h4444_4444);
        step();
        idle_inputs();
        set_r(0, 5'd9);
        set_r(1, 5'd4);
        @(negedge CLK);
        chk("run_busy_set", 64'(rbusy[0]), 64'h1);
        chk("run_data_set", 64'(rdat[DW +: DW]), 64'h4444_4444);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_busy_clr", 64'(rbusy[0]), 64'h0);
        chk("rst_data_clr", 64'(rdat[DW +: DW]), 64'h0);
        chk("rst_ready", 64'(ready), 64'h0);

        // Restart mid-sweep at index 10.
        repeat (10) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        wait_ready("ready_restart", 1'b0);
        @(negedge CLK);
        chk("restart_r4", 64'(rdat[DW +: DW]), 64'h0);

        // Randomised traffic; addresses biased low to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int w = 0; w < NW; w++) begin
                wen[w] = ($urandom_range(0, 2) != 0);
                wsel[w*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                wdat[w*DW +: DW] = $urandom;
            end
            for (int p = 0; p < NR; p++)
                rsel[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rsv_en = ($urandom_range(0, 2) == 0);
            rsv_sel = 5'($urandom_range(0, 7));
            RST = ($urandom_range(0, 599) == 0);
        end
        step();
        RST = 1'b0;
        idle_inputs();
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
